clock_switch_sequencer: RTL and testbench

Slow-domain controller that sequences a safe change of the producer clock select (150 MHz / 200 MHz) feeding the CDC FIFO write side. On request it pauses the producer, waits for the FIFO to drain, gates the selected clock, flips the select, waits for it to settle, then ungates and resumes. It runs on the slow clock and drives the clock-select mux, clock gate and producer enable. It replaces the static select input at the top level.

---
 rtl/clock_switch_sequencer.sv | 164 ++++++++++++++++
 tb/tb_clock_switch_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_switch_sequencer.sv
// Clock switch sequencer.
// Runs on the slow clock. It moves the producer clock select (0 = 150 MHz, 1 = 200 MHz)
// through a safe order: pause the producer, drain the FIFO, gate the clock, flip the
// select, let it settle, then ungate and resume.
module clock_switch_sequencer #(
  parameter int unsigned PAUSE_CYCLES   = 4,
  parameter int unsigned DRAIN_STABLE   = 8,
  parameter int unsigned GATE_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          RESET_SELECT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_Switch_Request,
  input  logic i_Target_Select,
  input  logic i_Fifo_Empty,
  output logic o_Selected_Clock,
  output logic o_Clock_Enable,
  output logic o_Producer_Enable,
  output logic o_Busy,
  output logic o_Done,
  output logic o_Abort,
  output logic o_Reject
);

  // Each counter is wide enough to hold its parameter value.
  localparam int unsigned PauseW   = $clog2(PAUSE_CYCLES + 1);
  localparam int unsigned StableW  = $clog2(DRAIN_STABLE + 1);
  localparam int unsigned GateW    = $clog2(GATE_CYCLES + 1);
  localparam int unsigned SettleW  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PauseW-1:0]   PauseLast   = PauseW'(PAUSE_CYCLES - 1);
  localparam logic [StableW-1:0]  StableMax   = StableW'(DRAIN_STABLE);
  localparam logic [GateW-1:0]    GateLast    = GateW'(GATE_CYCLES - 1);
  localparam logic [SettleW-1:0]  SettleLast  = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [TimeoutW-1:0] TimeoutMax  = TimeoutW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StPause,
    StDrain,
    StGate,
    StSwitch,
    StSettle
  } state_e;

  state_e              r_state;
  logic                r_target;
  logic [PauseW-1:0]   r_pause_cnt;
  logic [StableW-1:0]  r_stable_cnt;
  logic [GateW-1:0]    r_gate_cnt;
  logic [SettleW-1:0]  r_settle_cnt;
  logic [TimeoutW-1:0] r_timeout_cnt;

  logic [StableW-1:0]  w_stable_next;
  logic [TimeoutW-1:0] w_timeout_next;

  // Drain counter next values: stable run restarts on any non-empty cycle.
  always_comb begin
    w_stable_next  = i_Fifo_Empty ? (r_stable_cnt + StableW'(1)) : '0;
    w_timeout_next = r_timeout_cnt + TimeoutW'(1);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= StIdle;
      r_target          <= RESET_SELECT;
      r_pause_cnt       <= '0;
      r_stable_cnt      <= '0;
      r_gate_cnt        <= '0;
      r_settle_cnt      <= '0;
      r_timeout_cnt     <= '0;
      o_Selected_Clock  <= RESET_SELECT;
      o_Clock_Enable    <= 1'b1;
      o_Producer_Enable <= 1'b1;
      o_Busy            <= 1'b0;
      o_Done            <= 1'b0;
      o_Abort           <= 1'b0;
      o_Reject          <= 1'b0;
    end else begin
      o_Done   <= 1'b0;
      o_Abort  <= 1'b0;
      // Requests are only accepted in IDLE; this includes the exit cycle of a sequence.
      o_Reject <= i_Switch_Request && (r_state != StIdle);

      unique case (r_state)
        StIdle: begin
          if (i_Switch_Request) begin
            if (i_Target_Select == o_Selected_Clock) begin
              o_Done <= 1'b1;
            end else begin
              r_target          <= i_Target_Select;
              r_pause_cnt       <= '0;
              r_state           <= StPause;
              o_Busy            <= 1'b1;
              o_Producer_Enable <= 1'b0;
            end
          end
        end

        StPause: begin
          if (r_pause_cnt == PauseLast) begin
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_state       <= StDrain;
          end else begin
            r_pause_cnt <= r_pause_cnt + PauseW'(1);
          end
        end

        StDrain: begin
          r_stable_cnt  <= w_stable_next;
          r_timeout_cnt <= w_timeout_next;
          // Stable check first so it wins a tie with the timeout.
          if (w_stable_next == StableMax) begin
            r_gate_cnt     <= '0;
            r_state        <= StGate;
            o_Clock_Enable <= 1'b0;
          end else if (w_timeout_next == TimeoutMax) begin
            r_state           <= StIdle;
            o_Abort           <= 1'b1;
            o_Producer_Enable <= 1'b1;
            o_Busy            <= 1'b0;
          end
        end

        StGate: begin
          if (r_gate_cnt == GateLast) begin
            r_state <= StSwitch;
          end else begin
            r_gate_cnt <= r_gate_cnt + GateW'(1);
          end
        end

        StSwitch: begin
          // Clock is gated here, so the mux can change without glitching the producer.
          o_Selected_Clock <= r_target;
          r_settle_cnt     <= '0;
          r_state          <= StSettle;
        end

        StSettle: begin
          if (r_settle_cnt == SettleLast) begin
            r_state           <= StIdle;
            o_Clock_Enable    <= 1'b1;
            o_Producer_Enable <= 1'b1;
            o_Busy            <= 1'b0;
            o_Done            <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + SettleW'(1);
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Scoreboard bench for clock_switch_sequencer (default parameters).
// Stimulus pushes expected pulses, busy/gate window lengths and select changes into queues;
// negedge monitors pop and compare whenever the DUT shows the corresponding behaviour.
module tb_clock_switch_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic i_Switch_Request;
  logic i_Target_Select;
  logic i_Fifo_Empty;
  logic o_Selected_Clock;
  logic o_Clock_Enable;
  logic o_Producer_Enable;
  logic o_Busy;
  logic o_Done;
  logic o_Abort;
  logic o_Reject;

  clock_switch_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .i_Switch_Request  (i_Switch_Request),
    .i_Target_Select   (i_Target_Select),
    .i_Fifo_Empty      (i_Fifo_Empty),
    .o_Selected_Clock  (o_Selected_Clock),
    .o_Clock_Enable    (o_Clock_Enable),
    .o_Producer_Enable (o_Producer_Enable),
    .o_Busy            (o_Busy),
    .o_Done            (o_Done),
    .o_Abort           (o_Abort),
    .o_Reject          (o_Reject)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge is the index of the preceding rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
  endtask

  localparam int KDone = 1, KAbort = 2, KReject = 3;

  typedef struct { int kind; int at; int sel; } ev_t;
  typedef struct { int at; int val; int gated; } sel_t;

  ev_t  ev_q[$];
  sel_t sel_q[$];
  int   busy_q[$];
  int   gate_q[$];

  bit   mon_en = 1'b0;
  logic prev_busy, prev_ce, prev_sel;
  int   busy_start, gate_start;

  task automatic check_event(input int kind);
    ev_t e;
    if (ev_q.size() == 0) begin
      chk("unexpected_pulse_kind", kind, 0);
      return;
    end
    e = ev_q.pop_front();
    chk("pulse_kind", kind, e.kind);
    chk("pulse_edge", cyc, e.at);
    chk("pulse_sel", int'(o_Selected_Clock), e.sel);
    if (kind == KReject) begin
      chk("reject_busy", int'(o_Busy), 1);
    end else begin
      chk("exit_busy", int'(o_Busy), 0);
      chk("exit_clk_en", int'(o_Clock_Enable), 1);
      chk("exit_prod_en", int'(o_Producer_Enable), 1);
    end
  endtask

  // Monitor: pulses, window lengths, select changes and the enable ordering invariant.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_Done)   check_event(KDone);
      if (o_Abort)  check_event(KAbort);
      if (o_Reject) check_event(KReject);

      chk("prod_off_while_gated", int'(o_Producer_Enable && !o_Clock_Enable), 0);

      if (o_Busy && !prev_busy) busy_start = cyc;
      if (!o_Busy && prev_busy) begin
        if (busy_q.size() == 0) chk("unexpected_busy_len", cyc - busy_start, -1);
        else chk("busy_len", cyc - busy_start, busy_q.pop_front());
      end

      if (!o_Clock_Enable && prev_ce) gate_start = cyc;
      if (o_Clock_Enable && !prev_ce) begin
        if (gate_q.size() == 0) chk("unexpected_gate_len", cyc - gate_start, -1);
        else chk("gate_len", cyc - gate_start, gate_q.pop_front());
      end

      if (o_Selected_Clock != prev_sel) begin
        if (sel_q.size() == 0) begin
          chk("unexpected_sel_change", int'(o_Selected_Clock), -1);
        end else begin
          sel_t s;
          s = sel_q.pop_front();
          chk("sel_change_edge", cyc, s.at);
          chk("sel_change_val", int'(o_Selected_Clock), s.val);
          if (s.gated != 0) chk("sel_change_gated", int'(o_Clock_Enable), 0);
        end
      end
    end
    prev_busy = o_Busy;
    prev_ce   = o_Clock_Enable;
    prev_sel  = o_Selected_Clock;
  end

  // Issue a one-cycle request at the current negedge; returns the accepting edge index.
  task automatic do_req(input logic tgt, output int acc);
    i_Switch_Request = 1'b1;
    i_Target_Select  = tgt;
    acc = cyc + 1;
    @(negedge clk);
    i_Switch_Request = 1'b0;
  endtask

  // Advance to the negedge following edge c (inputs set there are sampled at edge c+1).
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag, input logic sel);
    chk({tag, "_sel"}, int'(o_Selected_Clock), int'(sel));
    chk({tag, "_clk_en"}, int'(o_Clock_Enable), 1);
    chk({tag, "_prod_en"}, int'(o_Producer_Enable), 1);
    chk({tag, "_busy"}, int'(o_Busy), 0);
  endtask

  // Full switch with an already empty FIFO: 31 busy, 19 gated, select at +15, done at +31.
  task automatic nominal_switch(input logic tgt);
    int a;
    i_Fifo_Empty = 1'b1;
    do_req(tgt, a);
    busy_q.push_back(31);
    gate_q.push_back(19);
    sel_q.push_back('{at: a + 15, val: int'(tgt), gated: 1});
    ev_q.push_back('{kind: KDone, at: a + 31, sel: int'(tgt)});
    wait_cyc(a + 40);
  endtask

  initial begin
    int a;
    reset            = 1'b1;
    i_Switch_Request = 1'b0;
    i_Target_Select  = 1'b0;
    i_Fifo_Empty     = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state.
    check_idle_outputs("reset", 1'b0);
    chk("reset_done", int'(o_Done), 0);
    chk("reset_abort", int'(o_Abort), 0);
    chk("reset_reject", int'(o_Reject), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // No-op request: done on the next edge, nothing else moves.
    do_req(1'b0, a);
    ev_q.push_back('{kind: KDone, at: a, sel: 0});
    wait_cyc(a + 5);
    check_idle_outputs("noop", 1'b0);

    // Nominal 0 -> 1.
    nominal_switch(1'b1);

    // 1 -> 0 with a drain glitch: 5 empty, 1 not empty, then 8 more empty.
    i_Fifo_Empty = 1'b0;
    do_req(1'b0, a);
    wait_cyc(a + 4);  i_Fifo_Empty = 1'b1;
    wait_cyc(a + 9);  i_Fifo_Empty = 1'b0;
    wait_cyc(a + 10); i_Fifo_Empty = 1'b1;
    busy_q.push_back(37);
    gate_q.push_back(19);
    sel_q.push_back('{at: a + 21, val: 0, gated: 1});
    ev_q.push_back('{kind: KDone, at: a + 37, sel: 0});
    wait_cyc(a + 45);
    check_idle_outputs("glitch_end", 1'b0);

    // Drain timeout: FIFO never empties, abort after 1024 drain cycles.
    i_Fifo_Empty = 1'b0;
    do_req(1'b1, a);
    busy_q.push_back(1028);
    ev_q.push_back('{kind: KAbort, at: a + 1028, sel: 0});
    wait_cyc(a + 1035);
    check_idle_outputs("abort_end", 1'b0);

    // Request during SETTLE is rejected; the original 0 -> 1 switch completes.
    i_Fifo_Empty = 1'b1;
    do_req(1'b1, a);
    busy_q.push_back(31);
    gate_q.push_back(19);
    sel_q.push_back('{at: a + 15, val: 1, gated: 1});
    wait_cyc(a + 19);
    do_req(1'b0, a);  // a now holds the reject edge (original accept + 20)
    ev_q.push_back('{kind: KReject, at: a, sel: 1});
    ev_q.push_back('{kind: KDone, at: a + 11, sel: 1});
    wait_cyc(a + 20);
    check_idle_outputs("reject_end", 1'b1);

    // Back to 0, then 0 -> 1 interrupted by reset in SETTLE.
    nominal_switch(1'b0);
    do_req(1'b1, a);
    sel_q.push_back('{at: a + 15, val: 1, gated: 1});
    sel_q.push_back('{at: a + 20, val: 0, gated: 0});
    busy_q.push_back(20);
    gate_q.push_back(8);
    wait_cyc(a + 19);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("mid_reset", 1'b0);
    chk("mid_reset_done", int'(o_Done), 0);
    repeat (40) @(negedge clk);
    check_idle_outputs("final", 1'b0);

    chk("events_left", ev_q.size(), 0);
    chk("sel_changes_left", sel_q.size(), 0);
    chk("busy_windows_left", busy_q.size(), 0);
    chk("gate_windows_left", gate_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got edge %0d, expected < 20000", cyc);
    $fatal(1);
  end

endmodule
